// File: rtl/modulo_entrada_pkg.sv
// modulo_entrada_pkg: shared FSM encodings and defaults for the input responder
package modulo_entrada_pkg;
  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] AGUARDA = 3'd1;
  localparam logic [2:0] CAPTURA = 3'd2;
  localparam logic [2:0] ENTREGA = 3'd3;
  localparam logic [2:0] SOLTA   = 3'd4;
endpackage

// File: rtl/modulo_entrada_debounce_botao.sv
// debounce_botao: synchronises and debounces the active-low confirm button
module debounce_botao
  import modulo_entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao_n,
  output logic premido,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic b1, b2, deb_n, flip;
  logic [CW-1:0] cnt;
  assign flip = (b2 != deb_n) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign premido = ~deb_n;
  // two-flop synchroniser, idles at released
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {b2, b1} <= 2'b11;
    else {b2, b1} <= {b1, botao_n};
  // level accepted only after a full stable run; counter stops at the flip point
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      deb_n <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      deb_n <= flip ? b2 : deb_n;
      cnt   <= (b2 == deb_n || flip) ? '0 : cnt + 1'b1;
      press <= flip & ~b2;
    end
endmodule

// File: rtl/modulo_entrada.sv
// modulo_entrada: waits for a debounced confirm press, captures switches, 4-phase ack
module modulo_entrada
  import modulo_entrada_pkg::*;
#(
  parameter int SW_WIDTH        = 7,
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  botao_n,
  input  logic                  in_req,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] dado,
  output logic                  aguardando
);
  logic [SW_WIDTH-1:0] sw1, sw2;
  logic [2:0] state, next;
  logic premido, press;

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock(clock), .reset_n(reset_n), .botao_n(botao_n), .premido(premido), .press(press)
  );

  // switch synchroniser
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {sw2, sw1} <= '0;
    else {sw2, sw1} <= {sw1, switches};

  // next state; a button already held at request time must be released first,
  // and a dropped request beats a simultaneous press
  always_comb
    next = (state == OCIOSO)  ? (in_req ? (premido ? SOLTA : AGUARDA) : OCIOSO) :
           (state == AGUARDA) ? (!in_req ? OCIOSO : (press ? CAPTURA : AGUARDA)) :
           (state == CAPTURA) ? ENTREGA :
           (state == ENTREGA) ? (in_req ? ENTREGA : SOLTA) :
           (state == SOLTA)   ? (premido ? SOLTA : OCIOSO) : OCIOSO;

  // state register and capture register; dado only changes on capture
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= OCIOSO;
      dado  <= '0;
    end else begin
      state <= next;
      dado  <= (state == CAPTURA) ? DATA_WIDTH'(sw2) : dado;
    end

  assign in_ack     = (state == ENTREGA);
  assign aguardando = (state == AGUARDA);
endmodule
